regfile_write_ctrl: RTL and testbench

- Write-side controller for the 4-register, 16-bit register file. It drives the file's `regwrite`/`wr`/`wd` write port.
- Accepts writeback requests from the datapath over a valid/ready handshake and buffers them in a small in-order FIFO.
- Retires at most one write per cycle onto the register file port.
- Provides combinational forwarding of pending (not-yet-written) values to the two read-address ports, so reads see the youngest value.

---
 rtl/regfile_write_ctrl_if.sv | 24 ++
 rtl/regfile_write_ctrl.sv | 139 +++++++++++++
 tb/tb_regfile_write_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_ctrl_if.sv
// Writeback request channel from the datapath into the register-file write controller.
interface regfile_write_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2
);
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_reg;
    logic [DATA_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_reg,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_reg,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/regfile_write_ctrl.sv
// Buffers writeback requests in an in-order FIFO, retires one per cycle onto the
// register file write port, and forwards the youngest pending value to two read ports.
module regfile_write_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic                clock,
    input  logic                resetn,
    regfile_write_ctrl_if.slave req,
    input  logic                drain_en,
    output logic                regwrite,
    output logic [ADDR_W-1:0]   wr,
    output logic [DATA_W-1:0]   wd,
    input  logic [ADDR_W-1:0]   rr1,
    input  logic [ADDR_W-1:0]   rr2,
    output logic                fwd_hit1,
    output logic                fwd_hit2,
    output logic [DATA_W-1:0]   fwd_data1,
    output logic [DATA_W-1:0]   fwd_data2,
    output logic                busy,
    output logic [ADDR_W:0]     count,
    output logic [7:0]          drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] mem_reg_q  [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [7:0]        drop_q, drop_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic in_ready;
    logic accept;
    logic push;
    logic pop;

    // Ready depends only on occupancy, so a full FIFO refuses even while popping.
    assign in_ready     = (count_q != CNT_W'(DEPTH));
    assign req.in_ready = in_ready;

    always_comb begin
        accept     = req.in_valid && in_ready;
        push       = accept && (req.in_reg != '0);
        pop        = (count_q != '0) && drain_en;
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        drop_d = drop_q;
        if (accept && (req.in_reg == '0) && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        regwrite_d = pop;
        wr_d       = wr_q;
        wd_d       = wd_q;
        if (pop) begin
            wr_d = mem_reg_q[rd_ptr_q];
            wd_d = mem_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            drop_q     <= '0;
            regwrite_q <= 1'b0;
            wr_q       <= '0;
            wd_q       <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_q     <= drop_d;
            regwrite_q <= regwrite_d;
            wr_q       <= wr_d;
            wd_q       <= wd_d;
        end
    end

    // Storage needs no reset: only entries inside the count window are ever read.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_reg_q[wr_ptr_q]  <= req.in_reg;
            mem_data_q[wr_ptr_q] <= req.in_data;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [ADDR_W-1:0] rr;
        logic              hit;
        logic [DATA_W-1:0] data;

        assign rr = (gi == 0) ? rr1 : rr2;

        // Scan the in-flight register first, then FIFO oldest to youngest so the youngest match wins.
        always_comb begin
            hit  = 1'b0;
            data = '0;
            if (rr != '0) begin
                if (regwrite_q && (wr_q == rr)) begin
                    hit  = 1'b1;
                    data = wd_q;
                end
                for (int j = 0; j < DEPTH; j++) begin
                    if ((CNT_W'(j) < count_q) &&
                        (mem_reg_q[rd_ptr_q + PTR_W'(j)] == rr)) begin
                        hit  = 1'b1;
                        data = mem_data_q[rd_ptr_q + PTR_W'(j)];
                    end
                end
            end
        end
    end

    assign fwd_hit1  = g_fwd[0].hit;
    assign fwd_data1 = g_fwd[0].data;
    assign fwd_hit2  = g_fwd[1].hit;
    assign fwd_data2 = g_fwd[1].data;

    assign regwrite  = regwrite_q;
    assign wr        = wr_q;
    assign wd        = wd_q;
    assign busy      = (count_q != '0) || regwrite_q;
    assign count     = (ADDR_W+1)'(count_q);
    assign drop_cnt  = drop_q;
endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_regfile_write_ctrl;
    logic        clock = 1'b0;
    logic        resetn;
    logic        drain_en;
    logic        regwrite;
    logic [1:0]  wr;
    logic [15:0] wd;
    logic [1:0]  rr1, rr2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic        busy;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;

    int pass_cnt  = 0;
    int total_cnt = 0;

    regfile_write_ctrl_if #(.DATA_W(16), .ADDR_W(2)) bus ();

    regfile_write_ctrl #(.DATA_W(16), .ADDR_W(2), .DEPTH(4)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (bus.slave),
        .drain_en  (drain_en),
        .regwrite  (regwrite),
        .wr        (wr),
        .wd        (wd),
        .rr1       (rr1),
        .rr2       (rr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .busy      (busy),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [1:0]  r;
        logic [15:0] d;
        logic        dr;
        logic [2:0]  cnt;
        logic        rdy;
        logic        rw;
        logic [1:0]  wr;
        logic [15:0] wd;
    } vec_t;

    typedef struct {
        logic [1:0]  r;
        logic [15:0] d;
    } ent_t;

    vec_t vecs [9];
    ent_t exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] r, input logic [15:0] d, input logic dr);
        bus.in_valid = v;
        bus.in_reg   = r;
        bus.in_data  = d;
        drain_en     = dr;
    endtask

    task automatic apply_vec(input int i);
        drive(vecs[i].v, vecs[i].r, vecs[i].d, vecs[i].dr);
        tick();
        $display("vec %0d: count=%0d ready=%0b regwrite=%0b wr=%0d wd=%0h", i, count, bus.in_ready, regwrite, wr, wd);
        check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
        check($sformatf("vec%0d_ready", i), 32'(bus.in_ready), 32'(vecs[i].rdy));
        check($sformatf("vec%0d_regwrite", i), 32'(regwrite), 32'(vecs[i].rw));
        check($sformatf("vec%0d_wr", i), 32'(wr), 32'(vecs[i].wr));
        check($sformatf("vec%0d_wd", i), 32'(wd), 32'(vecs[i].wd));
    endtask

    initial begin
        int   mcount;
        int   sent;
        logic pp;
        logic psh;
        logic seen_rw;
        ent_t e;
        ent_t h;

        vecs[0] = '{1'b1, 2'd1, 16'd1, 1'b0, 3'd1, 1'b1, 1'b0, 2'd1, 16'hA5A5};
        vecs[1] = '{1'b1, 2'd2, 16'd2, 1'b0, 3'd2, 1'b1, 1'b0, 2'd1, 16'hA5A5};
        vecs[2] = '{1'b1, 2'd3, 16'd3, 1'b0, 3'd3, 1'b1, 1'b0, 2'd1, 16'hA5A5};
        vecs[3] = '{1'b1, 2'd1, 16'd4, 1'b0, 3'd4, 1'b0, 1'b0, 2'd1, 16'hA5A5};
        vecs[4] = '{1'b0, 2'd0, 16'd0, 1'b1, 3'd3, 1'b1, 1'b1, 2'd1, 16'd1};
        vecs[5] = '{1'b0, 2'd0, 16'd0, 1'b1, 3'd2, 1'b1, 1'b1, 2'd2, 16'd2};
        vecs[6] = '{1'b0, 2'd0, 16'd0, 1'b1, 3'd1, 1'b1, 1'b1, 2'd3, 16'd3};
        vecs[7] = '{1'b0, 2'd0, 16'd0, 1'b1, 3'd0, 1'b1, 1'b1, 2'd1, 16'd4};
        vecs[8] = '{1'b0, 2'd0, 16'd0, 1'b1, 3'd0, 1'b1, 1'b0, 2'd1, 16'd4};

        resetn = 1'b0;
        drive(1'b0, 2'd0, 16'd0, 1'b0);
        rr1 = 2'd0;
        rr2 = 2'd0;
        #2;
        $display("reset: regwrite=%0b count=%0d busy=%0b drop=%0d", regwrite, count, busy, drop_cnt);
        check("rst_regwrite", 32'(regwrite), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clock);
        #5 resetn = 1'b1;

        // Single request, one-edge latency
        drive(1'b1, 2'd1, 16'hA5A5, 1'b1);
        tick();
        $display("t1 accept: count=%0d regwrite=%0b busy=%0b", count, regwrite, busy);
        check("t1_count", 32'(count), 32'd1);
        check("t1_rw_early", 32'(regwrite), 32'd0);
        check("t1_busy", 32'(busy), 32'd1);
        drive(1'b0, 2'd0, 16'd0, 1'b1);
        tick();
        $display("t1 retire: regwrite=%0b wr=%0d wd=%0h", regwrite, wr, wd);
        check("t1_rw", 32'(regwrite), 32'd1);
        check("t1_wr", 32'(wr), 32'd1);
        check("t1_wd", 32'(wd), 32'hA5A5);
        tick();
        $display("t1 after: regwrite=%0b busy=%0b", regwrite, busy);
        check("t1_rw_off", 32'(regwrite), 32'd0);
        check("t1_busy_off", 32'(busy), 32'd0);

        // Fill with drain held off, forward, then drain in order
        for (int i = 0; i < 4; i++) apply_vec(i);
        rr1 = 2'd1;
        rr2 = 2'd3;
        #1;
        $display("t2 fwd: hit1=%0b d1=%0h hit2=%0b d2=%0h", fwd_hit1, fwd_data1, fwd_hit2, fwd_data2);
        check("t2_hit1", 32'(fwd_hit1), 32'd1);
        check("t2_data1", 32'(fwd_data1), 32'd4);
        check("t2_hit2", 32'(fwd_hit2), 32'd1);
        check("t2_data2", 32'(fwd_data2), 32'd3);
        rr2 = 2'd2;
        #1;
        check("t2_data2_r2", 32'(fwd_data2), 32'd2);
        for (int i = 4; i < 9; i++) apply_vec(i);

        // Full FIFO with valid held, then streaming through pointer wrap
        mcount = 0;
        sent   = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            e.r = 2'((sent % 3) + 1);
            e.d = 16'h1000 + 16'(sent);
            drive(sent < 12, e.r, e.d, cyc >= 4);
            #1;
            check($sformatf("t3_ready_c%0d", cyc), 32'(bus.in_ready), 32'(mcount < 4));
            psh = (sent < 12) && (mcount < 4);
            pp  = (mcount > 0) && (cyc >= 4);
            if (pp) h = exp_q.pop_front();
            if (psh) begin
                exp_q.push_back(e);
                sent++;
            end
            mcount = mcount + (psh ? 1 : 0) - (pp ? 1 : 0);
            tick();
            $display("t3 c%0d: count=%0d regwrite=%0b wr=%0d wd=%0h", cyc, count, regwrite, wr, wd);
            check($sformatf("t3_count_c%0d", cyc), 32'(count), 32'(mcount));
            check($sformatf("t3_rw_c%0d", cyc), 32'(regwrite), 32'(pp));
            if (pp) begin
                check($sformatf("t3_wr_c%0d", cyc), 32'(wr), 32'(h.r));
                check($sformatf("t3_wd_c%0d", cyc), 32'(wd), 32'(h.d));
            end
        end

        // Register-0 writes are dropped and counted, saturating at 255
        rr1 = 2'd0;
        rr2 = 2'd0;
        drive(1'b1, 2'd0, 16'hFFFF, 1'b1);
        #1;
        check("t4_ready", 32'(bus.in_ready), 32'd1);
        check("t4_hit1_r0", 32'(fwd_hit1), 32'd0);
        check("t4_data1_r0", 32'(fwd_data1), 32'd0);
        tick();
        $display("t4 first: drop=%0d count=%0d regwrite=%0b", drop_cnt, count, regwrite);
        check("t4_drop1", 32'(drop_cnt), 32'd1);
        check("t4_count", 32'(count), 32'd0);
        seen_rw = regwrite;
        for (int i = 1; i < 300; i++) begin
            tick();
            seen_rw |= regwrite;
        end
        $display("t4 300 sent: drop=%0d seen_regwrite=%0b", drop_cnt, seen_rw);
        check("t4_drop_sat", 32'(drop_cnt), 32'd255);
        check("t4_no_rw", 32'(seen_rw), 32'd0);

        // Asynchronous reset with entries pending and a write in flight
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'((i % 3) + 1), 16'h0050 + 16'(i), 1'b0);
            tick();
        end
        drive(1'b0, 2'd0, 16'd0, 1'b1);
        tick();
        check("t5_pre_count", 32'(count), 32'd3);
        check("t5_pre_rw", 32'(regwrite), 32'd1);
        #3 resetn = 1'b0;
        #1;
        $display("t5 async reset: regwrite=%0b count=%0d busy=%0b drop=%0d", regwrite, count, busy, drop_cnt);
        check("t5_rw", 32'(regwrite), 32'd0);
        check("t5_count", 32'(count), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_drop", 32'(drop_cnt), 32'd0);
        check("t5_wr", 32'(wr), 32'd0);
        check("t5_wd", 32'(wd), 32'd0);
        @(posedge clock);
        @(posedge clock);
        #2 resetn = 1'b1;
        seen_rw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen_rw |= regwrite;
        end
        $display("t5 after release: seen_regwrite=%0b count=%0d", seen_rw, count);
        check("t5_no_stale", 32'(seen_rw), 32'd0);
        check("t5_count_after", 32'(count), 32'd0);
        drive(1'b1, 2'd3, 16'h0077, 1'b0);
        tick();
        check("t5_accept", 32'(count), 32'd1);
        drive(1'b0, 2'd0, 16'd0, 1'b1);
        tick();
        check("t5_wd_new", 32'(wd), 32'h0077);

        // Forwarding from the in-flight register, overridden by a newer queued write
        rr1 = 2'd2;
        rr2 = 2'd1;
        drive(1'b1, 2'd2, 16'h1234, 1'b1);
        tick();
        check("t6_q_hit1", 32'(fwd_hit1), 32'd1);
        check("t6_q_data1", 32'(fwd_data1), 32'h1234);
        drive(1'b0, 2'd0, 16'd0, 1'b1);
        tick();
        $display("t6 inflight: count=%0d rw=%0b hit1=%0b d1=%0h hit2=%0b", count, regwrite, fwd_hit1, fwd_data1, fwd_hit2);
        check("t6_count0", 32'(count), 32'd0);
        check("t6_if_hit1", 32'(fwd_hit1), 32'd1);
        check("t6_if_data1", 32'(fwd_data1), 32'h1234);
        check("t6_if_hit2", 32'(fwd_hit2), 32'd0);
        check("t6_if_data2", 32'(fwd_data2), 32'd0);
        drive(1'b1, 2'd2, 16'h1234, 1'b0);
        tick();
        drive(1'b1, 2'd2, 16'h5678, 1'b1);
        tick();
        $display("t6 newer: count=%0d wd=%0h hit1=%0b d1=%0h", count, wd, fwd_hit1, fwd_data1);
        check("t6_n_wd", 32'(wd), 32'h1234);
        check("t6_n_count", 32'(count), 32'd1);
        check("t6_n_data1", 32'(fwd_data1), 32'h5678);
        drive(1'b0, 2'd0, 16'd0, 1'b1);
        tick();
        check("t6_last_wd", 32'(wd), 32'h5678);
        tick();
        check("t6_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
